// File: rtl/seg7_pkg.sv
// seg7_pkg: seven-segment pattern constants shared by the display encoder and the
// frame receiver, plus the receiver FSM state type. Segment bit order is {g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;

  // BCD value reported alongside a failed decode; never a legal digit.
  localparam logic [3:0] INVALID = 4'hF;

  typedef enum logic {
    HUNT,
    RECV
  } rx_state_e;

endpackage

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode: combinational seven-segment pattern to BCD converter.
// Any pattern outside the ten digit glyphs (blank included) reports o_valid=0.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] i_pattern,
  output logic       o_valid,
  output logic [3:0] o_bcd
);

  always_comb begin
    o_valid = 1'b1;
    o_bcd   = INVALID;
    case (i_pattern)
      SEG_0:   o_bcd = 4'd0;
      SEG_1:   o_bcd = 4'd1;
      SEG_2:   o_bcd = 4'd2;
      SEG_3:   o_bcd = 4'd3;
      SEG_4:   o_bcd = 4'd4;
      SEG_5:   o_bcd = 4'd5;
      SEG_6:   o_bcd = 4'd6;
      SEG_7:   o_bcd = 4'd7;
      SEG_8:   o_bcd = 4'd8;
      SEG_9:   o_bcd = 4'd9;
      default: o_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_frame_rx.sv
// seg7_frame_rx: recovers HH:MM BCD frames from a multiplexed seven-segment stream.
// Define SEG7_RX_RANGE_CHECK_EN to reject aligned frames that are not a valid time of day.
module seg7_frame_rx
  import seg7_pkg::*;
#(
  parameter int SLOT_CYCLES   = 16,
  parameter int SAMPLE_OFFSET = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [6:0]  i_segments,
  input  logic        i_sync,
  output logic [15:0] o_digits,
  output logic        o_valid,
  output logic        o_err,
  output logic        o_locked
);

  localparam int CNT_W = $clog2(SLOT_CYCLES);
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] SAMPLE_AT = CNT_W'(SAMPLE_OFFSET);

  rx_state_e        r_state, w_stateNext;
  logic             r_syncQ;
  logic [CNT_W-1:0] r_slotCnt, w_slotCntNext;
  logic [1:0]       r_dig, w_digNext;
  logic [15:0]      r_shadow, w_shadowNext;
  logic [15:0]      r_digits, w_digitsNext;
  logic             r_valid, w_validNext;
  logic             r_err, w_errNext;

  logic             w_syncRise;
  logic             w_atWrap;
  logic             w_expectStart;
  logic             w_sample;
  logic             w_segOk;
  logic [3:0]       w_bcd;
  logic [15:0]      w_frame;
  logic             w_rangeOk;

  seg7_pattern_decode u_decode (
    .i_pattern (i_segments),
    .o_valid   (w_segOk),
    .o_bcd     (w_bcd)
  );

  assign w_syncRise    = i_sync & ~r_syncQ;
  assign w_atWrap      = (r_slotCnt == LAST_SLOT);
  assign w_expectStart = w_atWrap && (r_dig == 2'd3);
  assign w_sample      = (r_slotCnt == SAMPLE_AT);
  assign w_frame       = {r_shadow[15:4], w_bcd};

`ifdef SEG7_RX_RANGE_CHECK_EN
  assign w_rangeOk = ((w_frame[15:12] < 4'd2 && w_frame[11:8] <= 4'd9) ||
                      (w_frame[15:12] == 4'd2 && w_frame[11:8] <= 4'd3)) &&
                     (w_frame[7:4] <= 4'd5);
`else
  assign w_rangeOk = 1'b1;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= HUNT;
      r_syncQ   <= 1'b0;
      r_slotCnt <= '0;
      r_dig     <= 2'd0;
      r_shadow  <= 16'h0000;
      r_digits  <= 16'h0000;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_syncQ   <= i_sync;
      r_slotCnt <= w_slotCntNext;
      r_dig     <= w_digNext;
      r_shadow  <= w_shadowNext;
      r_digits  <= w_digitsNext;
      r_valid   <= w_validNext;
      r_err     <= w_errNext;
    end
  end

  // A misplaced sync edge outranks everything else in the same cycle, so a bad
  // pattern coinciding with it still yields one err and a realign, not a drop to HUNT.
  always_comb begin
    w_stateNext   = r_state;
    w_slotCntNext = r_slotCnt;
    w_digNext     = r_dig;
    w_shadowNext  = r_shadow;
    w_digitsNext  = r_digits;
    w_validNext   = 1'b0;
    w_errNext     = 1'b0;
    case (r_state)
      HUNT: begin
        if (w_syncRise) begin
          w_stateNext   = RECV;
          w_slotCntNext = '0;
          w_digNext     = 2'd0;
        end
      end
      RECV: begin
        if (w_atWrap) begin
          w_slotCntNext = '0;
          w_digNext     = r_dig + 2'd1;
        end else begin
          w_slotCntNext = r_slotCnt + CNT_W'(1);
        end

        if (w_syncRise && !w_expectStart) begin
          w_errNext     = 1'b1;
          w_slotCntNext = '0;
          w_digNext     = 2'd0;
        end else if (w_sample && !w_segOk) begin
          w_errNext     = 1'b1;
          w_stateNext   = HUNT;
          w_slotCntNext = '0;
          w_digNext     = 2'd0;
        end else begin
          if (w_sample) begin
            case (r_dig)
              2'd0:    w_shadowNext[15:12] = w_bcd;
              2'd1:    w_shadowNext[11:8]  = w_bcd;
              2'd2:    w_shadowNext[7:4]   = w_bcd;
              default: w_shadowNext[3:0]   = w_bcd;
            endcase
            if (r_dig == 2'd3) begin
              if (w_rangeOk) begin
                w_digitsNext = w_frame;
                w_validNext  = 1'b1;
              end else begin
                w_errNext = 1'b1;
              end
            end
          end
          if (w_expectStart && !w_syncRise) begin
            w_errNext     = 1'b1;
            w_stateNext   = HUNT;
            w_slotCntNext = '0;
            w_digNext     = 2'd0;
          end
        end
      end
      default: w_stateNext = HUNT;
    endcase
  end

  assign o_digits = r_digits;
  assign o_valid  = r_valid;
  assign o_err    = r_err;
  assign o_locked = (r_state == RECV);

endmodule
